// File: rtl/snd_pkg.sv
// Shared encodings for the sound command sequencer: FSM states, CPU register map,
// command-entry bit positions and status-register bit indices.
package snd_pkg;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WRITE = 2'd2,
        ST_WAIT  = 2'd3
    } seq_state_t;

    localparam logic [1:0] REG_DATA = 2'd0;
    localparam logic [1:0] REG_CMD  = 2'd1;
    localparam logic [1:0] REG_CTRL = 2'd2;
    localparam logic [1:0] REG_STAT = 2'd3;

    // Command byte sits in the upper half of a FIFO entry.
    localparam int CMD_WAIT = 7;
    localparam int ENT_WAIT = CMD_WAIT + 8;

    localparam int CTRL_RUN    = 0;
    localparam int CTRL_FLUSH  = 1;
    localparam int CTRL_IRQ_EN = 2;
    localparam int CTRL_ACK    = 3;

    localparam int STAT_OVF   = 7;
    localparam int STAT_IRQ   = 6;
    localparam int STAT_FULL  = 5;
    localparam int STAT_EMPTY = 4;
    localparam int STAT_BUSY  = 3;
endpackage

// File: rtl/snd_seq_fifo.sv
// Synchronous command FIFO, depth 2^AW; pop data appears one cycle after pop.
// Push while full is dropped; flush clears contents and beats a same-cycle push.
module snd_seq_fifo #(
    parameter int AW = 5,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic [DW-1:0] push_dat,
    input  logic          pop,
    output logic [DW-1:0] pop_dat,
    output logic [AW:0]   level,
    output logic          full,
    output logic          empty
);
    logic [DW-1:0] mem [0:(2**AW)-1];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (level == (AW+1)'(2**AW));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            level <= level + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_dat;
    end

    always_ff @(posedge clk) begin
        if (rst)         pop_dat <= '0;
        else if (do_pop) pop_dat <= mem[rd_ptr];
    end
endmodule

// File: rtl/snd_seq.sv
// Timed register-write sequencer: pops {cmd,data} entries and either strobes one synth
// write (registered, one cycle after WRITE sees snd_busy low) or waits N divider ticks.
module snd_seq
    import snd_pkg::*;
#(
    parameter int FIFO_AW  = 5,
    parameter int TICK_DIV = 16000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cs,
    input  logic       we,
    input  logic [1:0] addr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    input  logic       snd_busy,
    output logic       snd_cs,
    output logic       snd_we,
    output logic [3:0] snd_addr,
    output logic [7:0] snd_din,
    output logic       irq
);
    localparam int TW = $clog2(TICK_DIV);

    seq_state_t        state, state_nxt;
    logic [7:0]        data_stage;
    logic              run, irq_en, irq_flag, ovf, cmd_done;
    logic [TW-1:0]     tick_cnt;
    logic              tick;
    logic [14:0]       wait_cnt;
    logic [15:0]       fifo_dat;
    logic [FIFO_AW:0]  level;
    logic              full, empty;
    logic              cpu_wr, cpu_rd, push, ctrl_wr, flush, ack;
    logic              pop, load_wr, load_wait, strobe, dec, done;
    logic              wait_zero, busy, irq_set;

    assign cpu_wr    = cs && we;
    assign cpu_rd    = cs && !we;
    assign push      = cpu_wr && (addr == REG_CMD);
    assign ctrl_wr   = cpu_wr && (addr == REG_CTRL);
    assign flush     = ctrl_wr && din[CTRL_FLUSH];
    assign ack       = ctrl_wr && din[CTRL_ACK];
    assign wait_zero = (fifo_dat[14:0] == 15'd0);
    assign busy      = (state != ST_IDLE);
    assign tick      = (tick_cnt == TW'(TICK_DIV - 1));
    // A finished command raises the flag only once the queue has fully drained.
    assign irq_set   = cmd_done && run && (state == ST_IDLE) && empty;
    assign irq       = irq_flag && irq_en;

    snd_seq_fifo #(.AW(FIFO_AW), .DW(16)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .push     (push),
        .push_dat ({din, data_stage}),
        .pop      (pop),
        .pop_dat  (fifo_dat),
        .level    (level),
        .full     (full),
        .empty    (empty)
    );

    always_ff @(posedge clk) begin
        if (rst) tick_cnt <= '0;
        else if (tick) tick_cnt <= '0;
        else tick_cnt <= tick_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (run && !empty) state_nxt = ST_FETCH;
            ST_FETCH: begin
                if (!fifo_dat[ENT_WAIT]) state_nxt = ST_WRITE;
                else if (wait_zero)      state_nxt = ST_IDLE;
                else                     state_nxt = ST_WAIT;
            end
            ST_WRITE: if (!snd_busy) state_nxt = ST_IDLE;
            ST_WAIT:  if (tick && run && wait_cnt == 15'd1) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
        if (flush) state_nxt = ST_IDLE;
    end

    always_comb begin
        pop       = 1'b0;
        load_wr   = 1'b0;
        load_wait = 1'b0;
        strobe    = 1'b0;
        dec       = 1'b0;
        done      = 1'b0;
        if (!flush) begin
            case (state)
                ST_IDLE:  pop = run && !empty;
                ST_FETCH: begin
                    load_wr   = !fifo_dat[ENT_WAIT];
                    load_wait = fifo_dat[ENT_WAIT] && !wait_zero;
                    done      = fifo_dat[ENT_WAIT] && wait_zero;
                end
                ST_WRITE: begin
                    strobe = !snd_busy;
                    done   = !snd_busy;
                end
                ST_WAIT: begin
                    dec  = tick && run;
                    done = tick && run && (wait_cnt == 15'd1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
            snd_cs   <= 1'b0;
            snd_we   <= 1'b0;
            snd_addr <= '0;
            snd_din  <= '0;
        end else begin
            snd_cs <= strobe;
            snd_we <= strobe;
            if (load_wr) begin
                snd_addr <= fifo_dat[11:8];
                snd_din  <= fifo_dat[7:0];
            end
            if (load_wait) wait_cnt <= fifo_dat[14:0];
            else if (dec)  wait_cnt <= wait_cnt - 15'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_stage <= '0;
            run        <= 1'b0;
            irq_en     <= 1'b0;
            ovf        <= 1'b0;
            irq_flag   <= 1'b0;
            cmd_done   <= 1'b0;
        end else begin
            if (cpu_wr && addr == REG_DATA) data_stage <= din;
            if (ctrl_wr) begin
                run    <= din[CTRL_RUN];
                irq_en <= din[CTRL_IRQ_EN];
            end
            if (push && full) ovf <= 1'b1;
            else if (ack)     ovf <= 1'b0;
            if (irq_set)      irq_flag <= 1'b1;
            else if (ack)     irq_flag <= 1'b0;
            if (flush || pop || irq_set) cmd_done <= 1'b0;
            else if (done)               cmd_done <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) dout <= '0;
        else if (cpu_rd) begin
            case (addr)
                REG_DATA: dout <= data_stage;
                REG_CMD:  dout <= 8'(level);
                REG_CTRL: dout <= {5'b0, irq_en, 1'b0, run};
                default:  dout <= {ovf, irq_flag, full, empty, busy, 1'b0, state};
            endcase
        end
    end
endmodule
